// File: rtl/dm_arbiter.sv
// ---------------------------------------------------------------------------
// dm_arbiter
//   Shares a single-port, word-addressed data memory between the CPU
//   load/store port (A) and a DMA/debug port (B). Only one transaction is in
//   flight at a time. Sub-word stores become a read-modify-write: the old word
//   is read in ACC and the merged word is written in MERGE.
//
// Parameters
//   ADDR_W  word-index width driven to memory (byte address bits [ADDR_W+1:2])
//   RR      1 = round-robin between A and B on a tie, 0 = A always wins
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-low reset
//   req_x                 request level, fields held stable until ack_x
//   we_x                  1 = write, 0 = read
//   addr_x                byte address, bits [1:0] ignored
//   wdata_x, be_x         write data and byte enables (lane-aligned)
//   ack_x                 one-cycle completion pulse
//   rdata_x               registered read data, held until the next read on x
//   busy                  high whenever the sequencer is not idle
//   mem_addr/we/wdata     memory address, write strobe and write data
//   mem_rdata             combinational memory read data at mem_addr
// ---------------------------------------------------------------------------
module dm_arbiter #(
  parameter int ADDR_W = 10,
  parameter bit RR     = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [31:0]       addr_a,
  input  logic [31:0]       addr_b,
  input  logic [31:0]       wdata_a,
  input  logic [31:0]       wdata_b,
  input  logic [3:0]        be_a,
  input  logic [3:0]        be_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic [31:0]       rdata_a,
  output logic [31:0]       rdata_b,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    MERGE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_nextState;

  // Port ids: 0 = A, 1 = B.
  logic                r_lastGrant;
  logic                r_port;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_be;
  logic [31:0]         r_rdataA;
  logic [31:0]         r_rdataB;
  logic [31:0]         r_merge;

  logic                w_anyReq;
  logic                w_grantB;
  logic                w_fullWrite;
  logic                w_subWrite;
  logic [31:0]         w_mergeData;
  logic                w_memWe;
  logic [31:0]         w_memWdata;
  logic                w_unusedAddrBits;

  // Address bits outside the word index are deliberately dropped, which makes
  // addresses alias modulo the memory size.
  assign w_unusedAddrBits = ^{addr_a[31:ADDR_W+2], addr_a[1:0],
                              addr_b[31:ADDR_W+2], addr_b[1:0]};

  // Winner selection. On a tie with round-robin enabled the port that was
  // not granted last wins; last grant resets to B so A takes the first tie.
  always_comb begin
    w_anyReq = req_a | req_b;
    if (req_a && req_b) begin
      w_grantB = RR ? ~r_lastGrant : 1'b0;
    end else begin
      w_grantB = req_b;
    end
  end

  // Classify the latched transaction. be==0 writes fall into neither class
  // and complete as a no-op through ACC -> RESP.
  always_comb begin
    w_fullWrite = r_we && (r_be == 4'hF);
    w_subWrite  = r_we && (r_be != 4'hF) && (r_be != 4'h0);
  end

  // Byte-lane merge of the new write data over the word read in ACC.
  always_comb begin
    w_mergeData = r_merge;
    for (int i = 0; i < 4; i++) begin
      if (r_be[i]) begin
        w_mergeData[8*i +: 8] = r_wdata[8*i +: 8];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_anyReq) w_nextState = ACC;
      ACC:     w_nextState = w_subWrite ? MERGE : RESP;
      MERGE:   w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Memory write strobe and data: only a full write in ACC or the merged
  // write in MERGE ever touches the array.
  always_comb begin
    w_memWe    = 1'b0;
    w_memWdata = '0;
    case (r_state)
      ACC: begin
        if (w_fullWrite) begin
          w_memWe    = 1'b1;
          w_memWdata = r_wdata;
        end
      end
      MERGE: begin
        w_memWe    = 1'b1;
        w_memWdata = w_mergeData;
      end
      default: begin
        w_memWe    = 1'b0;
        w_memWdata = '0;
      end
    endcase
  end

  // State register, transaction latch and read-data capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_lastGrant <= 1'b1;
      r_port      <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_rdataA    <= '0;
      r_rdataB    <= '0;
      r_merge     <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_port  <= w_grantB;
            r_we    <= w_grantB ? we_b : we_a;
            r_addr  <= w_grantB ? addr_b[ADDR_W+1:2] : addr_a[ADDR_W+1:2];
            r_wdata <= w_grantB ? wdata_b : wdata_a;
            r_be    <= w_grantB ? be_b : be_a;
          end
        end
        ACC: begin
          if (!r_we) begin
            if (r_port) r_rdataB <= mem_rdata;
            else        r_rdataA <= mem_rdata;
          end else if (w_subWrite) begin
            r_merge <= mem_rdata;
          end
        end
        RESP: r_lastGrant <= r_port;
        default: ;
      endcase
    end
  end

  // The write strobe is qualified by reset so that a reset arriving during
  // MERGE suppresses the write at that same edge, leaving memory untouched.
  assign mem_we    = w_memWe & reset;
  assign mem_wdata = w_memWdata;
  assign mem_addr  = r_addr;
  assign busy      = (r_state != IDLE);
  assign ack_a     = (r_state == RESP) && !r_port;
  assign ack_b     = (r_state == RESP) &&  r_port;
  assign rdata_a   = r_rdataA;
  assign rdata_b   = r_rdataB;

endmodule

// File: tb/tb_dm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dm_arbiter
//   Drives the round-robin arbiter with directed and random traffic and
//   compares it cycle by cycle to a transaction-level reference model. A
//   second, fixed-priority instance checks that A starves B on a tie.
// ---------------------------------------------------------------------------
module tb_dm_arbiter;

  localparam int AW        = 10;
  localparam int MEM_WORDS = 1 << AW;

  logic          clk;
  logic          reset;
  logic          req_a, req_b, we_a, we_b;
  logic [31:0]   addr_a, addr_b, wdata_a, wdata_b;
  logic [3:0]    be_a, be_b;
  logic          ack_a, ack_b, busy, mem_we;
  logic [31:0]   rdata_a, rdata_b, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic          req0_a, req0_b;
  logic [31:0]   addr0_a, addr0_b;
  logic          ack_a0, ack_b0, busy0, mem_we0;
  logic [31:0]   rdata_a0, rdata_b0, unusedWdata0, mem_rdata0;
  logic [AW-1:0] mem_addr0;

  logic [31:0]   tbMem [0:MEM_WORDS-1];

  int            assertCount = 0;
  int            failCount   = 0;
  bit            ackOrder[$];

  // Reference model state.
  bit            modelOn = 1'b0;
  bit            mActive = 1'b0;
  bit            mLast   = 1'b1;
  bit            mWin;
  bit            mWe;
  bit            mRmw;
  logic [31:0]   mWdata;
  logic [3:0]    mBe;
  int            mIdx;
  int            mGrant;
  int            mLen;
  int            edgeNo = 0;
  logic [31:0]   mMem [0:MEM_WORDS-1];
  logic [31:0]   mRd [2];
  logic [1:0]    eAck;
  bit            eWe;
  bit            eAddrChk;
  logic [31:0]   eWdata;

  dm_arbiter #(.ADDR_W(AW), .RR(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .be_a(be_a), .be_b(be_b), .ack_a(ack_a), .ack_b(ack_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dm_arbiter #(.ADDR_W(AW), .RR(1'b0)) u_dutFixed (
    .clk(clk), .reset(reset),
    .req_a(req0_a), .req_b(req0_b), .we_a(1'b0), .we_b(1'b0),
    .addr_a(addr0_a), .addr_b(addr0_b), .wdata_a(32'd0), .wdata_b(32'd0),
    .be_a(4'h0), .be_b(4'h0), .ack_a(ack_a0), .ack_b(ack_b0),
    .rdata_a(rdata_a0), .rdata_b(rdata_b0), .busy(busy0),
    .mem_addr(mem_addr0), .mem_we(mem_we0), .mem_wdata(unusedWdata0),
    .mem_rdata(mem_rdata0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory array: combinational read, clocked write.
  assign mem_rdata = tbMem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) tbMem[mem_addr] <= mem_wdata;
  end

  // The fixed-priority instance reads back its own word index.
  assign mem_rdata0 = {22'd0, mem_addr0};

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] mergeWord(input logic [31:0] oldWord,
                                            input logic [31:0] newWord,
                                            input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? newWord[8*i +: 8] : oldWord[8*i +: 8];
    end
    return res;
  endfunction

  // Transaction-level model: tracks one in-flight transaction by the number
  // of edges since its grant and predicts what each following cycle shows.
  initial begin
    forever begin
      @(posedge clk);
      edgeNo++;
      eAck     = 2'b00;
      eWe      = 1'b0;
      eWdata   = '0;
      eAddrChk = 1'b0;
      if (!reset) begin
        modelOn = 1'b1;
        mActive = 1'b0;
        mLast   = 1'b1;
        mRd[0]  = '0;
        mRd[1]  = '0;
      end else if (modelOn) begin
        if (mActive) begin
          if (edgeNo - mGrant == 1 && !mWe) mRd[mWin] = mMem[mIdx];
          if (edgeNo - mGrant == 1 && mWe && mBe == 4'hF) mMem[mIdx] = mWdata;
          if (edgeNo - mGrant == 2 && mRmw) mMem[mIdx] = mergeWord(mMem[mIdx], mWdata, mBe);
          if (edgeNo - mGrant == mLen) begin
            mActive = 1'b0;
            mLast   = mWin;
          end
        end else if (req_a || req_b) begin
          mWin   = (req_a && req_b) ? ~mLast : req_b;
          mWe    = mWin ? we_b : we_a;
          mWdata = mWin ? wdata_b : wdata_a;
          mBe    = mWin ? be_b : be_a;
          mIdx   = int'(((mWin ? addr_b : addr_a) >> 2) % MEM_WORDS);
          mRmw   = mWe && (mBe != 4'hF) && (mBe != 4'h0);
          mLen   = mRmw ? 3 : 2;
          mGrant = edgeNo;
          mActive = 1'b1;
        end
        if (mActive) begin
          if (edgeNo == mGrant) begin
            eAddrChk = 1'b1;
            if (mWe && mBe == 4'hF) begin
              eWe    = 1'b1;
              eWdata = mWdata;
            end
          end
          if (edgeNo - mGrant == 1 && mRmw) begin
            eAddrChk = 1'b1;
            eWe      = 1'b1;
            eWdata   = mergeWord(mMem[mIdx], mWdata, mBe);
          end
          if (edgeNo - mGrant == mLen - 1) eAck[mWin] = 1'b1;
        end
      end
    end
  end

  // Compare the DUT against the model in the middle of every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (modelOn) begin
        checkOutput("ackA", ack_a, eAck[0]);
        checkOutput("ackB", ack_b, eAck[1]);
        checkOutput("busy", busy, mActive);
        checkOutput("memWe", mem_we, eWe & reset);
        if (eWe) checkOutput("memWdata", mem_wdata, eWdata);
        if (eAddrChk) checkOutput("memAddr", mem_addr, mIdx);
        checkOutput("rdataA", rdata_a, mRd[0]);
        checkOutput("rdataB", rdata_b, mRd[1]);
      end
    end
  end

  // One requester transaction: raise req with fields, wait (bounded) for
  // ack, drop req on the edge that samples ack. lat counts cycles to ack.
  task automatic applyStimulus(input bit portB, input bit we,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be,
                               output int lat, output logic [31:0] rd);
    bit seen;
    @(negedge clk);
    if (!portB) begin
      we_a = we; addr_a = addr; wdata_a = wdata; be_a = be; req_a = 1'b1;
    end else begin
      we_b = we; addr_b = addr; wdata_b = wdata; be_b = be; req_b = 1'b1;
    end
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 12) begin
      @(negedge clk);
      lat++;
      seen = portB ? ack_b : ack_a;
    end
    checkOutput(portB ? "ackSeenB" : "ackSeenA", seen, 1);
    rd = portB ? rdata_b : rdata_a;
    if (seen) ackOrder.push_back(portB);
    @(posedge clk);
    #1;
    if (!portB) req_a = 1'b0;
    else        req_b = 1'b0;
  endtask

  task automatic randomTxn(input bit portB);
    logic [31:0] r, wd, addr, rd;
    logic [9:0]  idx;
    logic [3:0]  be;
    bit          we;
    int          lat;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    r   = $urandom;
    wd  = $urandom;
    idx = 10'($urandom_range(0, 15));
    case ($urandom_range(0, 3))
      0:       be = 4'hF;
      1:       be = 4'h0;
      default: be = r[7:4];
    endcase
    we   = ($urandom_range(0, 1) == 1);
    addr = {r[31:12], idx, r[1:0]};
    applyStimulus(portB, we, addr, wd, be, lat, rd);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstMemAddr", mem_addr, 0);
    checkOutput("rstMemWe", mem_we, 0);
    checkOutput("rstRdataA", rdata_a, 0);
    checkOutput("rstRdataB", rdata_b, 0);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat, cntA, cntB;
    logic [31:0] rd;
    bit          seen, weSeen;

    reset = 1'b0;
    req_a = 0; req_b = 0; we_a = 0; we_b = 0;
    addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0; be_a = 0; be_b = 0;
    req0_a = 0; req0_b = 0;
    addr0_a = 32'h0000_0014;
    addr0_b = 32'h0000_0028;

    doReset();

    // Full-word write then read back on port A.
    applyStimulus(1'b0, 1'b1, 32'h10, 32'h12345678, 4'hF, lat, rd);
    checkOutput("latFullWrite", lat, 2);
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd);
    checkOutput("latRead", lat, 2);
    checkOutput("readBackA", rd, 32'h12345678);

    // Preload words used by the rest of the run.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 32'(i * 4), 32'h1111_0000 + 32'(i), 4'hF, lat, rd);
    end
    applyStimulus(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'hF, lat, rd);
    applyStimulus(1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, lat, rd);
    applyStimulus(1'b0, 1'b1, 32'h50, 32'h5555AAAA, 4'hF, lat, rd);

    // Sub-word write on port B.
    applyStimulus(1'b1, 1'b1, 32'h20, 32'h00001100, 4'b0010, lat, rd);
    checkOutput("latRmw", lat, 3);
    checkOutput("rmwWord", tbMem[8], 32'hAABB11DD);

    // be == 0 write is a no-op.
    applyStimulus(1'b0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, lat, rd);
    checkOutput("latBeZero", lat, 2);
    checkOutput("beZeroWord", tbMem[12], 32'hCAFEF00D);

    // Address aliasing: 0x1004 lands on word 1.
    applyStimulus(1'b0, 1'b1, 32'h1004, 32'h0BADBEEF, 4'hF, lat, rd);
    checkOutput("aliasWord", tbMem[1], 32'h0BADBEEF);
    applyStimulus(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, lat, rd);
    checkOutput("aliasRead", rd, 32'h0BADBEEF);

    // Tie-break after reset: A first, then alternating.
    doReset();
    ackOrder.delete();
    fork
      begin
        repeat (2) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd);
      end
      begin
        int latB;
        logic [31:0] rdB;
        repeat (2) applyStimulus(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, latB, rdB);
      end
    join
    checkOutput("orderSize", ackOrder.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ackOrder.size()) checkOutput($sformatf("order%0d", i), ackOrder[i], i % 2);
    end

    // Fixed priority: A held high starves B until A lets go.
    @(negedge clk);
    req0_a = 1'b1;
    req0_b = 1'b1;
    cntA   = 0;
    cntB   = 0;
    weSeen = 1'b0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      cntA   += int'(ack_a0);
      cntB   += int'(ack_b0);
      weSeen |= mem_we0;
    end
    checkOutput("fixedAcksA", cntA, 4);
    checkOutput("fixedAcksB", cntB, 0);
    checkOutput("fixedRdataA", rdata_a0, 32'd5);
    @(posedge clk);
    #1 req0_a = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      seen    = ack_b0;
      weSeen |= mem_we0;
    end
    checkOutput("fixedAckB", seen, 1);
    checkOutput("fixedRdataB", rdata_b0, 32'd10);
    checkOutput("fixedNoWrite", weSeen, 0);
    @(posedge clk);
    #1 req0_b = 1'b0;
    @(negedge clk);
    checkOutput("fixedIdle", busy0, 0);

    // Reset during MERGE aborts the RMW without touching memory.
    @(negedge clk);
    we_a = 1'b1; addr_a = 32'h50; wdata_a = 32'h00770000; be_a = 4'b0100;
    req_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
    req_a = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortRdataA", rdata_a, 0);
    @(negedge clk);
    checkOutput("abortMemWe", mem_we, 0);
    checkOutput("abortAck", ack_a, 0);
    checkOutput("abortWord", tbMem[20], 32'h5555AAAA);
    @(posedge clk);
    #1 reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h50, 32'h0, 4'h0, lat, rd);
    checkOutput("postAbortLat", lat, 2);
    checkOutput("postAbortRead", rd, 32'h5555AAAA);

    // Random concurrent traffic from both ports.
    fork
      begin
        for (int n = 0; n < 40; n++) randomTxn(1'b0);
      end
      begin
        for (int n = 0; n < 40; n++) randomTxn(1'b1);
      end
    join

    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("memWord%0d", i), tbMem[i], mMem[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
